// File: rtl/router_pkg.sv
// Shared router constants: default data width, port count and egress buffer depth.
// Used by the egress merge block and by the Router32 core.
package router_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_PORTS  = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int PORT_W     = $clog2(NUM_PORTS);

endpackage : router_pkg

// File: rtl/router_egress_fifo.sv
// Per-port egress buffer: a small circular FIFO with a show-ahead head word.
// A push into a full FIFO is ignored, judged on the count at the start of the cycle.
module router_egress_fifo
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = router_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH = router_pkg::FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] data
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1'b1);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1'b1);
    localparam logic [ADDR_W:0]   CNT_ZERO   = (ADDR_W + 1)'(1'b0);
    localparam logic [ADDR_W:0]   CNT_FULL   = (ADDR_W + 1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_r;
    logic [ADDR_W-1:0]     rd_ptr_r;
    logic [ADDR_W:0]       count_r;
    logic                  push_ok_s;
    logic                  pop_ok_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == CNT_ZERO);
    assign data      = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Storage array; contents are don't-care until the write pointer covers them.
    always_ff @(posedge clk) begin
        if (push_ok_s && !reset) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule : router_egress_fifo

// File: rtl/router_egress_merge.sv
// Merges NUM_PORTS router output streams into one ready/valid stream using
// per-port FIFOs, a round-robin arbiter and a single output register.
module router_egress_merge
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = router_pkg::DATA_WIDTH,
    parameter int NUM_PORTS  = router_pkg::NUM_PORTS,
    parameter int FIFO_DEPTH = router_pkg::FIFO_DEPTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_PORTS-1:0]            in_valid,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [$clog2(NUM_PORTS)-1:0]    out_port,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_PORTS-1:0]            drop,
    output logic                            busy
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam logic [PW:0]   NP_W      = (PW + 1)'(NUM_PORTS);
    localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);
    localparam logic [PW-1:0] PORT_ONE  = PW'(1'b1);

    logic [NUM_PORTS-1:0]  full_s;
    logic [NUM_PORTS-1:0]  empty_s;
    logic [NUM_PORTS-1:0]  pop_s;
    logic [DATA_WIDTH-1:0] head_s [NUM_PORTS];

    logic                  load_s;
    logic                  grant_found_s;
    logic [PW-1:0]         grant_idx_s;
    logic [PW-1:0]         next_rr_s;
    logic [PW:0]           sum_s;

    logic [PW-1:0]         rr_ptr_r;
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [PW-1:0]         out_port_r;
    logic [NUM_PORTS-1:0]  drop_r;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_fifo
        router_egress_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (in_valid[g]),
            .push_data (in_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .pop       (pop_s[g]),
            .full      (full_s[g]),
            .empty     (empty_s[g]),
            .data      (head_s[g])
        );
    end

    assign load_s    = ~out_valid_r | out_ready;
    assign next_rr_s = (grant_idx_s == LAST_PORT) ? {PW{1'b0}} : grant_idx_s + PORT_ONE;

    // Round-robin search: first non-empty FIFO at or above rr_ptr, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = {PW{1'b0}};
        sum_s         = {(PW + 1){1'b0}};
        for (int k = 0; k < NUM_PORTS; k++) begin
            sum_s = {1'b0, rr_ptr_r} + (PW + 1)'(k);
            if (sum_s >= NP_W) begin
                sum_s = sum_s - NP_W;
            end else begin
                sum_s = sum_s;
            end
            if (!grant_found_s && !empty_s[sum_s[PW-1:0]]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = sum_s[PW-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Pop exactly the granted FIFO when the output register takes a new word.
    always_comb begin
        pop_s = {NUM_PORTS{1'b0}};
        if (load_s && grant_found_s) begin
            pop_s[grant_idx_s] = 1'b1;
        end else begin
            pop_s = {NUM_PORTS{1'b0}};
        end
    end

    // Output register, round-robin pointer and sticky overflow flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r    <= {PW{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_port_r  <= {PW{1'b0}};
            drop_r      <= {NUM_PORTS{1'b0}};
        end else begin
            drop_r <= drop_r | (in_valid & full_s);
            if (load_s) begin
                if (grant_found_s) begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= head_s[grant_idx_s];
                    out_port_r  <= grant_idx_s;
                    rr_ptr_r    <= next_rr_s;
                end else begin
                    out_valid_r <= 1'b0;
                end
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_port  = out_port_r;
    assign drop      = drop_r;
    assign busy      = (~&empty_s) | out_valid_r;

endmodule : router_egress_merge

// File: tb/tb_router_egress_merge.sv
// Directed bench for router_egress_merge with hand-computed expectations.
module tb_router_egress_merge;

    logic         clk;
    logic         reset;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_port;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   drop;
    logic         busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int seen_cnt;

    router_egress_merge dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_port  (out_port),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop      (drop),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [31:0] v);
        in_data[p*32 +: 32] = v;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_data   = 128'h0;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_data",  64'(out_data),  64'h0);
        chk("rst_port",  64'(out_port),  64'h0);
        chk("rst_drop",  64'(drop),      64'h0);
        chk("rst_busy",  64'(busy),      64'h0);
        reset = 1'b0;

        // Single word latency: visible after the second edge, for one cycle.
        out_ready = 1'b1;
        in_valid  = 4'b0001;
        set_port(0, 32'hFFFFFFFF);
        tick();
        in_valid = 4'b0000;
        chk("lat_early_valid", 64'(out_valid), 64'h0);
        chk("lat_early_busy",  64'(busy),      64'h1);
        tick();
        chk("lat_valid", 64'(out_valid), 64'h1);
        chk("lat_data",  64'(out_data),  64'hFFFFFFFF);
        chk("lat_port",  64'(out_port),  64'h0);
        tick();
        chk("lat_gone",  64'(out_valid), 64'h0);
        chk("lat_idle",  64'(busy),      64'h0);

        // All four ports at once drain in port order.
        do_reset();
        in_valid = 4'b1111;
        set_port(0, 32'h11111111);
        set_port(1, 32'h22222222);
        set_port(2, 32'h33333333);
        set_port(3, 32'h44444444);
        tick();
        in_valid = 4'b0000;
        for (int p = 0; p < 4; p++) begin
            tick();
            chk("all_valid", 64'(out_valid), 64'h1);
            chk("all_port",  64'(out_port),  64'(p));
            chk("all_data",  64'(out_data),  64'(32'h11111111 * (p + 1)));
        end
        tick();
        chk("all_done", 64'(out_valid), 64'h0);

        // Backpressure: A0 held, A1..A4 buffered, A5 dropped.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 4'b0100;
            set_port(2, 32'hA0 + 32'(k));
            tick();
        end
        in_valid = 4'b0000;
        chk("bp_drop",  64'(drop),     64'h4);
        chk("bp_data",  64'(out_data), 64'hA0);
        chk("bp_port",  64'(out_port), 64'h2);
        tick();
        tick();
        chk("bp_hold_valid", 64'(out_valid), 64'h1);
        chk("bp_hold_data",  64'(out_data),  64'hA0);
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            chk("bp_drain_valid", 64'(out_valid), 64'h1);
            chk("bp_drain_data",  64'(out_data),  64'hA0 + 64'(k));
        end
        tick();
        chk("bp_drain_end", 64'(out_valid), 64'h0);
        chk("bp_drop_sticky", 64'(drop), 64'h4);

        // Ports 0 and 3 streaming: strict alternation, no overflow.
        do_reset();
        chk("rr_drop_clear", 64'(drop), 64'h0);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 4'b1001;
            set_port(0, 32'h100 + 32'(k));
            set_port(3, 32'h300 + 32'(k));
            tick();
            if (k >= 1) begin
                chk("rr_port", 64'(out_port), (k % 2 == 1) ? 64'h0 : 64'h3);
                chk("rr_data", 64'(out_data),
                    ((k % 2 == 1) ? 64'h100 : 64'h300) + 64'((k - 1) / 2));
            end
        end
        in_valid = 4'b0000;
        chk("rr_no_drop", 64'(drop), 64'h0);

        // Full FIFO1 pushed while popped: push lost, three words remain.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 4'b0010;
            set_port(1, 32'hB0 + 32'(k));
            tick();
        end
        chk("full_no_drop_yet", 64'(drop), 64'h0);
        out_ready = 1'b1;
        in_valid  = 4'b0010;
        set_port(1, 32'hB5);
        tick();
        in_valid = 4'b0000;
        chk("full_drop", 64'(drop),     64'h2);
        chk("full_head", 64'(out_data), 64'hB1);
        for (int k = 2; k < 5; k++) begin
            tick();
            chk("full_drain_valid", 64'(out_valid), 64'h1);
            chk("full_drain_data",  64'(out_data),  64'hB0 + 64'(k));
        end
        tick();
        chk("full_drain_end", 64'(out_valid), 64'h0);

        // Reset mid-operation discards buffered and registered words.
        out_ready = 1'b0;
        in_valid  = 4'b0111;
        set_port(0, 32'hC0);
        set_port(1, 32'hC1);
        set_port(2, 32'hC2);
        tick();
        in_valid = 4'b0000;
        tick();
        chk("mid_valid", 64'(out_valid), 64'h1);
        chk("mid_drop",  64'(drop),      64'h2);
        reset    = 1'b1;
        in_valid = 4'b1111;
        tick();
        reset    = 1'b0;
        in_valid = 4'b0000;
        chk("mid_rst_valid", 64'(out_valid), 64'h0);
        chk("mid_rst_busy",  64'(busy),      64'h0);
        chk("mid_rst_drop",  64'(drop),      64'h0);
        chk("mid_rst_data",  64'(out_data),  64'h0);
        out_ready = 1'b1;
        seen_cnt  = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_valid !== 1'b0) seen_cnt++;
        end
        chk("mid_stale_words", 64'(seen_cnt), 64'h0);
        chk("mid_end_busy",    64'(busy),     64'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_router_egress_merge

// File: doc/router_egress_merge.md
ROUTER_EGRESS_MERGE -- requirements
Module: router_egress_merge

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of one port data word.
REQ-002 Parameter NUM_PORTS, default 4: number of router output ports merged.
REQ-003 Parameter FIFO_DEPTH, default 4: words buffered per port; power of two, >=2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_data  input  NUM_PORTS*DATA_WIDTH  router output data; port i = in_data[i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 in_valid  input  NUM_PORTS  bit i qualifies port i word; no backpressure toward router.
REQ-008 out_data  output  DATA_WIDTH  merged data word.
REQ-009 out_port  output  clog2(NUM_PORTS)  source port index of out_data.
REQ-010 out_valid  output  1  out_data/out_port valid.
REQ-011 out_ready  input  1  downstream accepts word when out_valid & out_ready at rising edge.
REQ-012 drop  output  NUM_PORTS  sticky per-port overflow flag.
REQ-013 busy  output  1  high when any FIFO non-empty or out_valid high.

Function
REQ-014 Block SHALL write port i word into FIFO i at the edge where in_valid[i]=1 and FIFO i not full.
REQ-015 Fullness SHALL be evaluated from start-of-cycle count; push to a full FIFO is dropped even if the same FIFO pops that cycle, and drop[i] SHALL set.
REQ-016 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave count unchanged.
REQ-017 Output register SHALL load when empty (out_valid=0) or being consumed (out_valid & out_ready).
REQ-018 On load, arbiter SHALL grant the first non-empty FIFO searching upward (with wrap) from port rr_ptr; rr_ptr then SHALL become granted port + 1 modulo NUM_PORTS.
REQ-019 With no non-empty FIFO at a load opportunity, out_valid SHALL go to 0 at the next edge.
REQ-020 While out_valid=1 and out_ready=0, out_data and out_port SHALL hold stable.
REQ-021 Latency: word sampled at edge N into an empty, idle block SHALL appear with out_valid=1 after edge N+1.
REQ-022 Throughput: one word per cycle sustained when out_ready=1 and data pending.
REQ-023 Per-port ordering SHALL be preserved; no word is duplicated or lost except per REQ-015.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-025 drop[i] SHALL remain set until reset.

Reset
REQ-026 Reset SHALL clear all FIFO pointers/counts, rr_ptr=0, out_valid=0, out_data=0, out_port=0, drop=0; busy=0 thereafter.
REQ-027 Reset asserted mid-operation SHALL discard all buffered and registered words; none emitted after reset.
REQ-028 in_valid during reset SHALL be ignored.

Structure
REQ-029 Shared package router_pkg SHALL hold DATA_WIDTH, NUM_PORTS, FIFO_DEPTH defaults and PORT_W = clog2(NUM_PORTS), shared with Router32.
REQ-030 Per-port buffer SHALL be sub-module router_egress_fifo (push, pop, full, empty, data), instantiated NUM_PORTS times via generate.
REQ-031 Arbiter, rr_ptr and output register SHALL reside in router_egress_merge.

Verification
REQ-032 Reset, then in_valid=4'b0001, port0=32'hFFFFFFFF one cycle, out_ready=1 -> out_valid=1 two edges later, out_data=FFFFFFFF, out_port=0, one cycle only.
REQ-033 All ports valid one cycle with 11111111/22222222/33333333/44444444, out_ready=1 -> out_port 0,1,2,3 on four consecutive cycles, matching data.
REQ-034 out_ready=0, port2 sends A0..A5 on six consecutive cycles -> A0 held on output, A1-A4 buffered, A5 dropped, drop=4'b0100; out_ready=1 -> A0..A4 in order, then out_valid=0.
REQ-035 Ports 0 and 3 valid every cycle, out_ready=1 -> out_port alternates 0,3,0,3; no drops.
REQ-036 FIFO1 full, out_ready=1 pops port1 while in_valid[1]=1 same cycle -> word dropped, drop[1]=1, count decrements by one.
REQ-037 Three FIFOs holding data, reset one cycle -> out_valid=0, busy=0, drop=0; no stale word emitted over 10 following cycles with in_valid=0.
